// File: rtl/cache_pkg.sv
// Shared types and address-field constants for the
// direct-mapped instruction cache.
package cache_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM_READ,
    S_UPDATE
  } state_e;

  localparam int BLOCK_BYTES     = 16;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int WORD_BITS       = 32;
  localparam int BLOCK_BITS      = BLOCK_BYTES * 8;

  localparam int OFFSET_LSB   = 2;
  localparam int OFFSET_W     = 2;
  localparam int INDEX_LSB    = 4;
  localparam int BLOCK_ADDR_W = 28;

endpackage

// File: rtl/icache_storage.sv
// Valid/tag/data arrays: one combinational read port,
// one synchronous write port, async clear of valid bits.
module icache_storage
  import cache_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int TAG_W      = BLOCK_ADDR_W - INDEX_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INDEX_BITS-1:0] rd_idx_i,
  output logic                  rd_valid_o,
  output logic [TAG_W-1:0]      rd_tag_o,
  output logic [BLOCK_BITS-1:0] rd_data_o,
  input  logic                  wr_en_i,
  input  logic [INDEX_BITS-1:0] wr_idx_i,
  input  logic [TAG_W-1:0]      wr_tag_i,
  input  logic [BLOCK_BITS-1:0] wr_data_i
);

  localparam int NB = 1 << INDEX_BITS;

  logic [NB-1:0]         valid_q;
  logic [TAG_W-1:0]      tag_q  [NB];
  logic [BLOCK_BITS-1:0] data_q [NB];

  // Valid bits: cleared by reset, set on a block fill
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data payload, written on a block fill
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with a
// single-block refill FSM toward instruction memory.
module instruction_cache
  import cache_pkg::*;
#(
  parameter int INDEX_BITS = 3
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [31:0]             PC,
  output logic [31:0]             INSTRUCTION,
  output logic                    BUSYWAIT,
  output logic                    MEM_READ,
  output logic [BLOCK_ADDR_W-1:0] MEM_ADDRESS,
  input  logic [BLOCK_BITS-1:0]   MEM_READDATA,
  input  logic                    MEM_BUSYWAIT
);

  localparam int TAG_W = BLOCK_ADDR_W - INDEX_BITS;

  state_e                  state_q;
  logic [BLOCK_ADDR_W-1:0] miss_addr_q;
  logic [BLOCK_BITS-1:0]   fill_q;
  logic                    mem_read_q;

  logic [INDEX_BITS-1:0] pc_idx;
  logic [TAG_W-1:0]      pc_tag;
  logic [OFFSET_W-1:0]   pc_off;

  logic                  rd_valid;
  logic [TAG_W-1:0]      rd_tag;
  logic [BLOCK_BITS-1:0] rd_data;

  logic [WORDS_PER_BLOCK-1:0][WORD_BITS-1:0] rd_words;

  logic hit;
  logic wr_en;
  logic unused_pc;

  assign pc_idx    = PC[INDEX_LSB +: INDEX_BITS];
  assign pc_tag    = PC[31 -: TAG_W];
  assign pc_off    = PC[OFFSET_LSB +: OFFSET_W];
  assign unused_pc = ^PC[1:0];
  assign rd_words  = rd_data;

  assign wr_en = (state_q == S_UPDATE);

  icache_storage #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_storage (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .rd_idx_i   (pc_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_en_i    (wr_en),
    .wr_idx_i   (miss_addr_q[INDEX_BITS-1:0]),
    .wr_tag_i   (miss_addr_q[BLOCK_ADDR_W-1 -: TAG_W]),
    .wr_data_i  (fill_q)
  );

  // Hit detect; an unknown compare falls to the miss path
  always_comb begin
    hit = 1'b0;
    if (state_q == S_IDLE && rd_valid && rd_tag == pc_tag) begin
      hit = 1'b1;
    end
  end

  // Stall and instruction outputs, quiet during reset
  always_comb begin
    BUSYWAIT    = 1'b1;
    INSTRUCTION = 32'd0;
    if (RESET) begin
      BUSYWAIT = 1'b0;
    end else if (hit) begin
      BUSYWAIT    = 1'b0;
      INSTRUCTION = rd_words[pc_off];
    end
  end

  // Refill FSM: latch miss address, fetch block, write it
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      miss_addr_q <= '0;
      fill_q      <= '0;
      mem_read_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!hit) begin
            miss_addr_q <= PC[31:INDEX_LSB];
            mem_read_q  <= 1'b1;
            state_q     <= S_MEM_READ;
          end
        end
        S_MEM_READ: begin
          if (!MEM_BUSYWAIT) begin
            fill_q     <= MEM_READDATA;
            mem_read_q <= 1'b0;
            state_q    <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign MEM_READ    = mem_read_q;
  assign MEM_ADDRESS = miss_addr_q;

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache with a latency-
// programmable memory model and expected-result queues.
module tb_instruction_cache;

  logic         CLK;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  int errors = 0;
  int checks = 0;

  int lat = 4;
  int cnt = 0;
  logic ovr = 1'b0;

  typedef struct {
    int          stall;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [27:0] exp_addr_q[$];

  logic        prev_read = 1'b0;
  logic [27:0] held_addr = '0;

  instruction_cache dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [127:0] blk(input logic [27:0] a);
    if (a == 28'd0)
      return {32'h002081B3, 32'h00A00113,
              32'h00500093, 32'h00000013};
    return {a, 4'h3, a, 4'h2, a, 4'h1, a, 4'h0};
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] p);
    logic [127:0] b;
    b = blk(p[31:4]);
    return b[p[3:2]*32 +: 32];
  endfunction

  // memory model: N-cycle read, data valid while busywait low
  always @(posedge CLK) cnt <= MEM_READ ? cnt + 1 : 0;
  assign MEM_BUSYWAIT = !ovr && MEM_READ && (cnt < lat - 1);
  assign MEM_READDATA = blk(MEM_ADDRESS);

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // request monitor: each new MEM_READ pops an expected address
  always @(negedge CLK) begin
    if (MEM_READ && !prev_read) begin
      if (exp_addr_q.size() == 0) begin
        chk("unexpected_read", {4'h0, MEM_ADDRESS}, 32'hFFFFFFFF);
      end else begin
        chk("mem_address", {4'h0, MEM_ADDRESS},
            {4'h0, exp_addr_q.pop_front()});
      end
      held_addr <= MEM_ADDRESS;
    end else if (MEM_READ && prev_read) begin
      chk("addr_stable", {4'h0, MEM_ADDRESS}, {4'h0, held_addr});
    end
    prev_read <= MEM_READ;
  end

  // present pc, optionally move it after chg_at edges, count stalls
  task automatic fetch(input string tag,
                       input logic [31:0] pc,
                       input int n,
                       input int exp_stall,
                       input logic [31:0] ipc,
                       input int chg_at,
                       input logic [31:0] chg_pc);
    exp_t e;
    int stalls;
    int edges;
    bit done;
    logic [31:0] got;
    e.stall = exp_stall;
    e.instr = word_of(ipc);
    exp_q.push_back(e);
    lat = n;
    PC = pc;
    stalls = 0;
    edges = 0;
    done = 0;
    got = '0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (!BUSYWAIT) begin
        done = 1;
        got = INSTRUCTION;
        break;
      end
      stalls++;
      @(posedge CLK);
      #1;
      edges++;
      if (edges == chg_at) PC = chg_pc;
    end
    e = exp_q.pop_front();
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_stall"}, stalls, e.stall);
    chk({tag, "_instr"}, got, e.instr);
    chk({tag, "_pending"}, exp_addr_q.size(), 32'd0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b0;
    PC = 32'h0;
    #2 RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy", {31'd0, BUSYWAIT}, 32'd0);
    chk("rst_read", {31'd0, MEM_READ}, 32'd0);
    chk("rst_instr", INSTRUCTION, 32'd0);
    chk("rst_addr", {4'h0, MEM_ADDRESS}, 32'd0);
    RESET = 1'b0;

    exp_addr_q.push_back(28'h0000000);
    fetch("cold", 32'h0, 4, 6, 32'h0, 0, 0);
    chk("cold_word0", word_of(32'h0), 32'h00000013);
    fetch("hit4", 32'h4, 4, 0, 32'h4, 0, 0);
    fetch("hit8", 32'h8, 4, 0, 32'h8, 0, 0);
    fetch("hitC", 32'hC, 4, 0, 32'hC, 0, 0);
    chk("hitC_word", word_of(32'hC), 32'h002081B3);

    exp_addr_q.push_back(28'h0000008);
    fetch("conf80", 32'h80, 4, 6, 32'h80, 0, 0);
    exp_addr_q.push_back(28'h0000000);
    fetch("conf00", 32'h0, 4, 6, 32'h0, 0, 0);

    exp_addr_q.push_back(28'h0000001);
    exp_addr_q.push_back(28'h0000004);
    fetch("move", 32'h10, 4, 12, 32'h40, 1, 32'h40);
    fetch("hit10", 32'h10, 4, 0, 32'h10, 0, 0);
    fetch("hit44", 32'h44, 4, 0, 32'h44, 0, 0);

    lat = 10;
    exp_addr_q.push_back(28'h0000002);
    PC = 32'h20;
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    chk("pre_rst_read", {31'd0, MEM_READ}, 32'd1);
    RESET = 1'b1;
    #1;
    chk("mid_rst_read", {31'd0, MEM_READ}, 32'd0);
    chk("mid_rst_busy", {31'd0, BUSYWAIT}, 32'd0);
    chk("mid_rst_instr", INSTRUCTION, 32'd0);
    ovr = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    ovr = 1'b0;
    RESET = 1'b0;

    exp_addr_q.push_back(28'h0000002);
    fetch("after_rst", 32'h20, 4, 6, 32'h20, 0, 0);
    exp_addr_q.push_back(28'h0000000);
    fetch("n1_miss", 32'h0, 1, 3, 32'h0, 0, 0);
    fetch("n1_hit", 32'h8, 1, 0, 32'h8, 0, 0);
    fetch("hit24", 32'h24, 1, 0, 32'h24, 0, 0);

    chk("addr_q_empty", exp_addr_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_cache.md
# instruction_cache

Direct-mapped, read-only instruction cache between the fetch-stage PC and instruction memory. It returns the 32-bit instruction for the current PC in the same cycle on a hit. On a miss it drives BUSYWAIT, which stalls the PC and the IF/ID pipeline register, and refills one 16-byte block from instruction memory through a read/busywait handshake. It is the responder for the BUSYWAIT stall that the IF/ID register and PC logic consume.

## Interface
- INDEX_BITS, default 3: number of index bits; the cache holds 2^INDEX_BITS blocks (8).
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- PC  in  32  fetch address; PC[1:0] ignored, PC[3:2] word offset, PC[3+INDEX_BITS:4] index, upper bits tag.
- INSTRUCTION  out  32  selected instruction word; valid whenever BUSYWAIT=0.
- BUSYWAIT  out  1  high while the requested word is not available.
- MEM_READ  out  1  read request to instruction memory.
- MEM_ADDRESS  out  28  block address, PC[31:4] latched at miss entry.
- MEM_READDATA  in  128  refill block; word 0 in bits [31:0].
- MEM_BUSYWAIT  in  1  memory busy; data is valid in the cycle it is low while MEM_READ=1.

## Operation
- Storage per block: valid bit, tag (28-INDEX_BITS bits), 128-bit data.
- Hit is combinational: valid[index] && tag[index]==PC tag. It is evaluated only in IDLE.
- States:
  - IDLE: on hit, BUSYWAIT=0 and INSTRUCTION = data[index] word PC[3:2]. On miss, BUSYWAIT=1 combinationally, latch PC[31:4] into the miss address, and go to MEM_READ at the next edge.
  - MEM_READ: MEM_READ=1, MEM_ADDRESS = latched address, BUSYWAIT=1. At an edge with MEM_BUSYWAIT=0, capture MEM_READDATA into the fill buffer, deassert MEM_READ and go to UPDATE.
  - UPDATE: BUSYWAIT=1. At the edge, write the fill buffer, tag and valid=1 into the latched index, then go to IDLE.
- A PC that changes during a refill does not corrupt the fill, because the index, tag and address all come from the latched miss address. On return to IDLE the current PC is re-evaluated and may miss again.
- Any X or Z on PC while in IDLE is treated as a miss only when RESET=0. No write path exists; the cache is never dirty.
- Reset, including mid-refill:
  - clears all valid bits and returns the FSM to IDLE;
  - forces MEM_READ=0, BUSYWAIT=0 and INSTRUCTION=32'd0 while RESET is high;
  - any memory response after an aborted refill is ignored.

## Timing
- Hit: INSTRUCTION is valid in the same cycle PC is presented, for capture by IF/ID at the next rising edge. Zero stall cycles.
- Miss with a memory latency of N cycles (MEM_BUSYWAIT high for N-1 cycles after MEM_READ rises):
  - Cycle 0: BUSYWAIT rises combinationally.
  - Edge 1: enter MEM_READ; MEM_READ rises.
  - Edge N+1: data captured; enter UPDATE.
  - Edge N+2: array written; enter IDLE.
  - BUSYWAIT falls in cycle N+2 with a valid INSTRUCTION. Miss penalty is N+2 cycles.
- MEM_READ and MEM_ADDRESS are held stable for the whole MEM_READ state.
- Reset values: state IDLE, all valid=0, fill buffer and miss address 0, MEM_READ=0.
- Back-to-back misses to different blocks: one IDLE evaluation cycle separates the refills; BUSYWAIT stays high through it.

## Structure
- Shared package cache_pkg:
  - state enum (IDLE, MEM_READ, UPDATE);
  - BLOCK_BYTES=16 and WORDS_PER_BLOCK=4;
  - address field offset constants.
- One sub-module, icache_storage: valid, tag and data arrays with an asynchronous clear of the valid bits, one combinational read port and one synchronous write port. The FSM and the hit logic stay in instruction_cache.

## Test plan
- Cold miss: after reset, PC=0x00000000 and memory returns block {0x00000013,0x00500093,0x00A00113,0x002081B3} with N=4 -> BUSYWAIT high for 6 cycles, MEM_ADDRESS=0x0000000, then INSTRUCTION=0x00000013.
- Sequential hits: PC=0x4, 0x8, 0xC after the fill -> BUSYWAIT=0 every cycle; INSTRUCTION=0x00500093, 0x00A00113, 0x002081B3.
- Conflict: PC=0x00000080 (same index 0, tag differs) -> miss with MEM_ADDRESS=0x0000008. A later PC=0x00000000 misses again.
- PC changes mid-refill: PC moves from 0x10 to 0x40 during MEM_READ -> MEM_ADDRESS stays 0x0000001 and index 1 is filled. After UPDATE, 0x40 misses with MEM_ADDRESS=0x0000004.
- Reset mid-refill: assert RESET in cycle 2 of MEM_READ -> MEM_READ=0 immediately with no valid bit set. A late MEM_BUSYWAIT=0 is ignored, and the first PC after release misses.
- Memory with N=1 (MEM_BUSYWAIT never high) -> miss penalty of exactly 3 cycles.
